// File: rtl/ram_line_bridge_if.sv
// Line-side and RAM-side signal bundle for ram_line_bridge.
// slave = bridge view, master = cache/RAM-model view.
interface ram_line_bridge_if #(
  parameter int unsigned ADDR_SIZE     = 13,
  parameter int unsigned RAM_WORD_SIZE = 16,
  parameter int unsigned LINE_WIDTH    = 64
);
  logic                     line_req;
  logic                     line_rnw;
  logic [ADDR_SIZE-1:0]     line_addr;
  logic [LINE_WIDTH-1:0]    line_wdata;
  logic                     line_ready;
  logic                     line_done;
  logic                     line_err;
  logic [LINE_WIDTH-1:0]    line_rdata;
  logic [ADDR_SIZE-1:0]     ram_addr;
  logic [RAM_WORD_SIZE-1:0] ram_wdata;
  logic                     ram_avalid;
  logic                     ram_rnw;
  logic [RAM_WORD_SIZE-1:0] ram_rdata;
  logic                     ram_rack;

  modport slave (
    input  line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_rack,
    output line_ready, line_done, line_err, line_rdata,
           ram_addr, ram_wdata, ram_avalid, ram_rnw
  );

  modport master (
    output line_req, line_rnw, line_addr, line_wdata, ram_rdata, ram_rack,
    input  line_ready, line_done, line_err, line_rdata,
           ram_addr, ram_wdata, ram_avalid, ram_rnw
  );
endinterface

// File: rtl/ram_line_bridge.sv
// ram_line_bridge: serialises one cache-line read/write into RAM-word beats.
// Optional read watchdog enabled by defining RAM_TIMEOUT_EN.
module ram_line_bridge #(
  parameter int unsigned ADDR_SIZE      = 13,
  parameter int unsigned RAM_WORD_SIZE  = 16,
  parameter int unsigned LINE_WIDTH     = 64,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic              ram_clk,
  input  logic              ram_rst,
  ram_line_bridge_if.slave  bus
);
  localparam int unsigned BEATS = LINE_WIDTH / RAM_WORD_SIZE;
  localparam int unsigned CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int unsigned WD_W  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CMD  = 3'd1;
  localparam logic [2:0] S_WR   = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Reject geometries the beat indexing cannot handle.
  if ((BEATS == 0) || ((LINE_WIDTH % RAM_WORD_SIZE) != 0) ||
      ((BEATS & (BEATS - 1)) != 0) || (TIMEOUT_CYCLES == 0)) begin : g_bad_cfg
    $error("ram_line_bridge: unsupported LINE_WIDTH/RAM_WORD_SIZE/TIMEOUT_CYCLES");
  end

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0]     addr_q, addr_d;
  logic                     rnw_q, rnw_d;
  logic [LINE_WIDTH-1:0]    wdata_q, wdata_d;
  logic [LINE_WIDTH-1:0]    rd_buf_q, rd_buf_d;
  logic [LINE_WIDTH-1:0]    line_rdata_q, line_rdata_d;
  logic [RAM_WORD_SIZE-1:0] ram_wdata_q, ram_wdata_d;
  logic                     ram_avalid_q, ram_avalid_d;
  logic                     line_ready_q, line_ready_d;
  logic                     line_done_q, line_done_d;
  logic                     line_err_q, line_err_d;
  logic                     timed_out;
`ifdef RAM_TIMEOUT_EN
  logic [WD_W-1:0]          wdog_q, wdog_d;
`endif

  // Next-state, capture and registered-output computation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    addr_d       = addr_q;
    rnw_d        = rnw_q;
    wdata_d      = wdata_q;
    rd_buf_d     = rd_buf_q;
    line_rdata_d = line_rdata_q;
    timed_out    = 1'b0;
`ifdef RAM_TIMEOUT_EN
    wdog_d       = wdog_q;
`endif

    case (state_q)
      S_IDLE: begin
        if (bus.line_req) begin
          addr_d  = bus.line_addr;
          rnw_d   = bus.line_rnw;
          wdata_d = bus.line_wdata;
          cnt_d   = '0;
          state_d = S_CMD;
        end
      end
      S_CMD: begin
        if (rnw_q) begin
          cnt_d   = '0;
          state_d = S_RD;
        end else begin
          cnt_d   = CNT_W'(1);
          state_d = S_WR;
        end
`ifdef RAM_TIMEOUT_EN
        wdog_d = '0;
`endif
      end
      S_WR: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_BEAT) state_d = S_DONE;
      end
      S_RD: begin
        if (bus.ram_rack) begin
          rd_buf_d[int'(cnt_q)*RAM_WORD_SIZE +: RAM_WORD_SIZE] = bus.ram_rdata;
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == LAST_BEAT) begin
            line_rdata_d = rd_buf_d;
            state_d      = S_DONE;
          end
`ifdef RAM_TIMEOUT_EN
          wdog_d = '0;
        end else if (wdog_q == WD_W'(TIMEOUT_CYCLES - 1)) begin
          timed_out = 1'b1;
          cnt_d     = '0;
          state_d   = S_DONE;
        end else begin
          wdog_d = wdog_q + WD_W'(1);
`endif
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    ram_avalid_d = (state_d == S_CMD);
    line_ready_d = (state_d == S_IDLE);
    line_done_d  = (state_d == S_DONE);
    line_err_d   = timed_out;
    if (((state_d == S_CMD) && !rnw_d) || (state_d == S_WR))
      ram_wdata_d = wdata_d[int'(cnt_d)*RAM_WORD_SIZE +: RAM_WORD_SIZE];
    else
      ram_wdata_d = '0;
  end

  // State and output registers; reset abandons any transfer in flight.
  always_ff @(posedge ram_clk or posedge ram_rst) begin
    if (ram_rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      addr_q       <= '0;
      rnw_q        <= 1'b0;
      wdata_q      <= '0;
      rd_buf_q     <= '0;
      line_rdata_q <= '0;
      ram_wdata_q  <= '0;
      ram_avalid_q <= 1'b0;
      line_ready_q <= 1'b1;
      line_done_q  <= 1'b0;
      line_err_q   <= 1'b0;
`ifdef RAM_TIMEOUT_EN
      wdog_q       <= '0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      addr_q       <= addr_d;
      rnw_q        <= rnw_d;
      wdata_q      <= wdata_d;
      rd_buf_q     <= rd_buf_d;
      line_rdata_q <= line_rdata_d;
      ram_wdata_q  <= ram_wdata_d;
      ram_avalid_q <= ram_avalid_d;
      line_ready_q <= line_ready_d;
      line_done_q  <= line_done_d;
      line_err_q   <= line_err_d;
`ifdef RAM_TIMEOUT_EN
      wdog_q       <= wdog_d;
`endif
    end
  end

  assign bus.line_ready = line_ready_q;
  assign bus.line_done  = line_done_q;
  assign bus.line_err   = line_err_q;
  assign bus.line_rdata = line_rdata_q;
  assign bus.ram_addr   = addr_q;
  assign bus.ram_rnw    = rnw_q;
  assign bus.ram_wdata  = ram_wdata_q;
  assign bus.ram_avalid = ram_avalid_q;
endmodule

// File: tb/tb_ram_line_bridge.sv
// Self-checking bench for ram_line_bridge with a line-level reference model.
module tb_ram_line_bridge;
  localparam int unsigned AW = 13;
  localparam int unsigned WW = 16;
  localparam int unsigned LW = 64;
  localparam int unsigned BEATS = LW / WW;
  localparam int unsigned TMO = 8;

  logic ram_clk = 1'b0;
  logic ram_rst;
  always #5 ram_clk = ~ram_clk;

  ram_line_bridge_if #(.ADDR_SIZE(AW), .RAM_WORD_SIZE(WW), .LINE_WIDTH(LW)) bus ();

  ram_line_bridge #(
    .ADDR_SIZE(AW), .RAM_WORD_SIZE(WW), .LINE_WIDTH(LW), .TIMEOUT_CYCLES(TMO)
  ) dut (
    .ram_clk (ram_clk),
    .ram_rst (ram_rst),
    .bus     (bus)
  );

  int vectors = 0;
  int miscompares = 0;
  logic [LW-1:0] model_rdata = '0;   // last line delivered by a completed read

  // {line_ready, line_done, line_err, ram_avalid, ram_rnw}
  function automatic logic [4:0] status();
    return {bus.line_ready, bus.line_done, bus.line_err, bus.ram_avalid, bus.ram_rnw};
  endfunction

  task automatic tick();
    @(posedge ram_clk);
    #1;
  endtask

  task automatic drive_idle();
    bus.line_req = 1'b0; bus.line_rnw = 1'b0; bus.line_addr = '0; bus.line_wdata = '0;
    bus.ram_rack = 1'b0; bus.ram_rdata = '0;
  endtask

  task automatic test_reset();
    ram_rst = 1'b1;
    drive_idle();
    #3;
    vectors++;
    if (status() !== 5'b10000) begin
      miscompares++; $display("FAIL reset_status got %b want %b", status(), 5'b10000);
    end
    vectors++;
    if ({bus.line_rdata, bus.ram_addr, bus.ram_wdata} !== '0) begin
      miscompares++; $display("FAIL reset_data got %h/%h/%h want 0", bus.line_rdata, bus.ram_addr, bus.ram_wdata);
    end
    tick(); tick();
    ram_rst = 1'b0;
    tick();
  endtask

  // Write one line; poke holds line_req high through the busy cycles.
  task automatic do_write(input logic [AW-1:0] addr, input logic [LW-1:0] line, input bit poke);
    logic [WW-1:0] beat;
    bus.line_req = 1'b1; bus.line_rnw = 1'b0; bus.line_addr = addr; bus.line_wdata = line;
    tick();
    bus.line_req = poke; bus.line_addr = ~addr; bus.line_wdata = ~line;
    for (int b = 0; b < int'(BEATS); b++) begin
      if (b > 0) tick();
      beat = line[b*WW +: WW];
      vectors++;
      if (status() !== {4'b000, b == 0, 1'b0}) begin
        miscompares++; $display("FAIL wr_status beat %0d got %b want %b", b, status(), {4'b000, b == 0, 1'b0});
      end
      vectors++;
      if ({bus.ram_addr, bus.ram_wdata} !== {addr, beat}) begin
        miscompares++; $display("FAIL wr_beat %0d got addr %h data %h want addr %h data %h", b, bus.ram_addr, bus.ram_wdata, addr, beat);
      end
    end
    tick();
    vectors++;
    if ({status(), bus.ram_wdata} !== {5'b01000, WW'(0)}) begin
      miscompares++; $display("FAIL wr_done got %b/%h want 01000/0", status(), bus.ram_wdata);
    end
    tick();
    bus.line_req = 1'b0;
    vectors++;
    if (status() !== 5'b10000) begin
      miscompares++; $display("FAIL wr_ready got %b want 10000", status());
    end
    tick();
    vectors++;
    if (status() !== 5'b10000) begin
      miscompares++; $display("FAIL wr_no_reaccept got %b want 10000", status());
    end
  endtask

  // Read one line; gaps[b] idle cycles precede beat b.
  task automatic do_read(input logic [AW-1:0] addr, input logic [LW-1:0] line, input int gaps[BEATS]);
    bus.line_req = 1'b1; bus.line_rnw = 1'b1; bus.line_addr = addr;
    tick();
    bus.line_req = 1'b0;
    vectors++;
    if ({status(), bus.ram_addr, bus.ram_wdata} !== {5'b00011, addr, WW'(0)}) begin
      miscompares++; $display("FAIL rd_cmd got %b/%h/%h want 00011/%h/0", status(), bus.ram_addr, bus.ram_wdata, addr);
    end
    bus.ram_rack = 1'b1; bus.ram_rdata = 16'hFFFF;   // must be ignored in CMD
    tick();
    for (int b = 0; b < int'(BEATS); b++) begin
      for (int g = 0; g < gaps[b]; g++) begin
        bus.ram_rack = 1'b0; bus.ram_rdata = WW'($urandom);
        tick();
        vectors++;
        if ({status(), bus.line_rdata} !== {5'b00001, model_rdata}) begin
          miscompares++; $display("FAIL rd_gap beat %0d got %b/%h want 00001/%h", b, status(), bus.line_rdata, model_rdata);
        end
      end
      bus.ram_rack = 1'b1; bus.ram_rdata = line[b*WW +: WW];
      tick();
      if (b < int'(BEATS) - 1) begin
        vectors++;
        if (status() !== 5'b00001) begin
          miscompares++; $display("FAIL rd_wait beat %0d got %b want 00001", b, status());
        end
      end
    end
    bus.ram_rack = 1'b0;
    model_rdata = line;
    vectors++;
    if ({status(), bus.line_rdata, bus.ram_addr} !== {5'b01001, model_rdata, addr}) begin
      miscompares++; $display("FAIL rd_done got %b/%h/%h want 01001/%h/%h", status(), bus.line_rdata, bus.ram_addr, model_rdata, addr);
    end
    tick();
    vectors++;
    if ({status(), bus.line_rdata} !== {5'b10001, model_rdata}) begin
      miscompares++; $display("FAIL rd_hold got %b/%h want 10001/%h", status(), bus.line_rdata, model_rdata);
    end
  endtask

  task automatic test_write();
    do_write(13'h1ABC, 64'hdeadbeef10009abc, 1'b1);
    for (int i = 0; i < 8; i++)
      do_write(AW'($urandom), {$urandom, $urandom}, 1'($urandom));
  endtask

  task automatic test_read_b2b();
    int gaps[BEATS] = '{0, 0, 0, 0};
    do_read(13'h0ABC, 64'h3333222211116000, gaps);
  endtask

  task automatic test_read_gaps();
    int gaps[BEATS] = '{0, 2, 0, 1};
    do_read(13'h0123, 64'h000D000C000B000A, gaps);
    for (int i = 0; i < 8; i++) begin
      foreach (gaps[b]) gaps[b] = int'($urandom_range(0, 3));
      do_read(AW'($urandom), {$urandom, $urandom}, gaps);
    end
  endtask

  task automatic test_ignored();
    bus.ram_rack = 1'b1; bus.ram_rdata = 16'hFFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if ({bus.line_ready, bus.line_done, bus.ram_avalid, bus.line_rdata} !== {3'b100, model_rdata}) begin
        miscompares++; $display("FAIL idle_rack got %b%b%b/%h want 100/%h", bus.line_ready, bus.line_done, bus.ram_avalid, bus.line_rdata, model_rdata);
      end
    end
    bus.ram_rack = 1'b0;
  endtask

  task automatic test_reset_mid_read();
    int gaps[BEATS] = '{0, 1, 0, 2};
    bus.line_req = 1'b1; bus.line_rnw = 1'b1; bus.line_addr = 13'h0777;
    tick();
    bus.line_req = 1'b0;
    tick();
    for (int b = 0; b < 2; b++) begin
      bus.ram_rack = 1'b1; bus.ram_rdata = WW'($urandom);
      tick();
    end
    bus.ram_rack = 1'b0;
    #2 ram_rst = 1'b1;
    #1;
    model_rdata = '0;
    vectors++;
    if ({status(), bus.line_rdata, bus.ram_addr, bus.ram_wdata} !== {5'b10000, LW'(0), AW'(0), WW'(0)}) begin
      miscompares++; $display("FAIL midrst_immediate got %b/%h/%h/%h want 10000/0/0/0", status(), bus.line_rdata, bus.ram_addr, bus.ram_wdata);
    end
    tick(); tick();
    ram_rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++;
      if (status() !== 5'b10000) begin
        miscompares++; $display("FAIL midrst_no_done got %b want 10000", status());
      end
    end
    do_read(AW'($urandom), {$urandom, $urandom}, gaps);
  endtask

  task automatic test_timeout();
    int gaps[BEATS] = '{1, 0, 0, 0};
    bus.line_req = 1'b1; bus.line_rnw = 1'b1; bus.line_addr = 13'h1555;
    tick();
    bus.line_req = 1'b0;
`ifdef RAM_TIMEOUT_EN
    for (int k = 1; k <= int'(TMO) + 1; k++) begin
      tick();
      vectors++;
      if ({bus.line_ready, bus.line_done, bus.line_err, bus.line_rdata} !==
          {1'b0, k == int'(TMO) + 1, k == int'(TMO) + 1, model_rdata}) begin
        miscompares++; $display("FAIL timeout cycle %0d got %b%b%b/%h want 0%b%b/%h", k, bus.line_ready,
          bus.line_done, bus.line_err, bus.line_rdata, k == int'(TMO) + 1, k == int'(TMO) + 1, model_rdata);
      end
    end
    tick();
    vectors++;
    if ({bus.line_ready, bus.line_done, bus.line_err} !== 3'b100) begin
      miscompares++; $display("FAIL timeout_recover got %b%b%b want 100", bus.line_ready, bus.line_done, bus.line_err);
    end
`else
    for (int k = 1; k <= 100; k++) begin
      tick();
      vectors++;
      if ({bus.line_ready, bus.line_done, bus.line_err} !== 3'b000) begin
        miscompares++; $display("FAIL no_timeout cycle %0d got %b%b%b want 000", k, bus.line_ready, bus.line_done, bus.line_err);
      end
    end
    ram_rst = 1'b1;
    tick();
    ram_rst = 1'b0;
    model_rdata = '0;
`endif
    do_read(AW'($urandom), {$urandom, $urandom}, gaps);
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_b2b();
    test_read_gaps();
    test_ignored();
    test_write();
    test_ignored();
    test_reset_mid_read();
    test_timeout();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
